// File: rtl/nibble_mayor_driver.sv
// Issues multi-nibble operand pairs to a fixed-latency nibble comparator, MSB nibble first,
// and reassembles the returned per-nibble maxima into one result word.
module nibble_mayor_driver #(
  parameter int N_PARES  = 2,
  parameter int LATENCIA = 4,
  localparam int W       = 4 * N_PARES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [3:0]   nm_a,
  output logic [3:0]   nm_b,
  input  logic [3:0]   nm_mayor,
  output logic         out_valid,
  output logic [W-1:0] out_mayor
);

  localparam int CNT_W = $clog2(N_PARES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          state_reg, state_next;
  logic [W-1:0]        a_sh_reg, b_sh_reg;
  logic [CNT_W-1:0]    issue_cnt_reg, cap_cnt_reg;
  logic [LATENCIA-1:0] tag_sr_reg;
  logic [3:0]          nm_a_reg, nm_b_reg;
  logic                in_ready_reg, out_valid_reg;

  logic accept, sending, capture, last_issue, last_capture;

  assign accept       = in_valid && in_ready_reg;
  assign sending      = (state_reg == SEND);
  assign capture      = tag_sr_reg[LATENCIA-1];
  assign last_issue   = (issue_cnt_reg == CNT_W'(N_PARES));
  assign last_capture = capture && (cap_cnt_reg == CNT_W'(N_PARES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last_issue) state_next = WAIT;
      WAIT:    if (last_capture) state_next = DONE;
      DONE:    state_next = accept ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are held as shift registers so the next nibble to issue is always the top one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      issue_cnt_reg <= '0;
      cap_cnt_reg   <= '0;
      nm_a_reg      <= '0;
      nm_b_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next == IDLE) || (state_next == DONE);
      out_valid_reg <= (state_next == DONE);
      if (accept) begin
        a_sh_reg      <= in_a << 4;
        b_sh_reg      <= in_b << 4;
        nm_a_reg      <= in_a[W-1 -: 4];
        nm_b_reg      <= in_b[W-1 -: 4];
        issue_cnt_reg <= CNT_W'(1);
      end else if (sending && !last_issue) begin
        a_sh_reg      <= a_sh_reg << 4;
        b_sh_reg      <= b_sh_reg << 4;
        nm_a_reg      <= a_sh_reg[W-1 -: 4];
        nm_b_reg      <= b_sh_reg[W-1 -: 4];
        issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
      end else begin
        nm_a_reg <= '0;
        nm_b_reg <= '0;
      end
      if (accept) begin
        cap_cnt_reg <= '0;
      end else if (capture) begin
        cap_cnt_reg <= cap_cnt_reg + CNT_W'(1);
      end
    end
  end

  // A tag enters stage 0 at the end of the cycle its pair is on nm_a/nm_b,
  // so it reaches the last stage exactly when that pair's maximum arrives.
  for (genvar gi = 0; gi < LATENCIA; gi++) begin : g_tag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_sr_reg[gi] <= 1'b0;
      end else if (gi == 0) begin
        tag_sr_reg[gi] <= sending;
      end else begin
        tag_sr_reg[gi] <= tag_sr_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  end

  // Captures arrive MSB nibble first, so capture k lands in nibble N_PARES-1-k.
  for (genvar gi = 0; gi < N_PARES; gi++) begin : g_nib
    logic [3:0] nib_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        nib_reg <= '0;
      end else if (capture && (cap_cnt_reg == CNT_W'(N_PARES - 1 - gi))) begin
        nib_reg <= nm_mayor;
      end
    end
    assign out_mayor[4*gi +: 4] = nib_reg;
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign nm_a      = nm_a_reg;
  assign nm_b      = nm_b_reg;

endmodule

// File: tb/tb_nibble_mayor_driver.sv
// Scoreboard bench: two driver instances (2 and 4 nibble pairs), each with a behavioural comparator.
module tb_nibble_mayor_driver;
  localparam int L  = 4;
  localparam int N2 = 2;
  localparam int W2 = 8;
  localparam int N4 = 4;
  localparam int W4 = 16;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done4 = 1'b0;
  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;

  logic          reset, in_valid, in_ready, out_valid;
  logic [W2-1:0] in_a, in_b, out_mayor;
  logic [3:0]    nm_a, nm_b, nm_mayor;

  logic          reset4, in_valid4, in_ready4, out_valid4;
  logic [W4-1:0] in_a4, in_b4, out_mayor4;
  logic [3:0]    nm_a4, nm_b4, nm_mayor4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_mayor_driver #(.N_PARES(N2), .LATENCIA(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .nm_a(nm_a), .nm_b(nm_b), .nm_mayor(nm_mayor),
    .out_valid(out_valid), .out_mayor(out_mayor)
  );

  nibble_mayor_driver #(.N_PARES(N4), .LATENCIA(L)) dut4 (
    .clk(clk), .reset(reset4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .nm_a(nm_a4), .nm_b(nm_b4), .nm_mayor(nm_mayor4),
    .out_valid(out_valid4), .out_mayor(out_mayor4)
  );

  // Behavioural comparators: max of the presented pair appears L cycles later.
  logic [3:0] pipe2 [1:L];
  logic [3:0] pipe4 [1:L];
  always @(posedge clk) begin
    pipe2[1] <= (nm_a > nm_b) ? nm_a : nm_b;
    pipe4[1] <= (nm_a4 > nm_b4) ? nm_a4 : nm_b4;
    for (int k = 2; k <= L; k++) begin
      pipe2[k] <= pipe2[k-1];
      pipe4[k] <= pipe4[k-1];
    end
  end
  assign nm_mayor  = pipe2[L];
  assign nm_mayor4 = pipe4[L];

  function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b, input int n);
    logic [15:0] r;
    int na, nb;
    r = '0;
    for (int i = 0; i < n; i++) begin
      na = int'((a >> (4 * i)) & 16'hF);
      nb = int'((b >> (4 * i)) & 16'hF);
      r = r | (16'((na > nb) ? na : nb) << (4 * i));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid at cycle %0d: got out_mayor=%h, want no output", cyc, out_mayor);
      end else begin
        e2 = q2.pop_front();
        check("result", 32'(out_mayor), 32'(e2.val));
        check("latency", 32'(cyc), 32'(e2.at));
        $display("N2 result %h at cycle %0d", out_mayor, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (reset4 === 1'b0 && out_valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid4 at cycle %0d: got out_mayor=%h, want no output", cyc, out_mayor4);
      end else begin
        e4 = q4.pop_front();
        check("result4", 32'(out_mayor4), 32'(e4.val));
        check("latency4", 32'(cyc), 32'(e4.at));
        $display("N4 result %h at cycle %0d", out_mayor4, cyc);
      end
    end
  end

  // Offers a pair, checks the issued nibbles, optionally keeps in_valid high with junk while busy.
  task automatic send2(input logic [7:0] a, input logic [7:0] b, input bit busy, output int t0);
    int   guard;
    logic [7:0] ea, eb;
    exp_t e;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    t0 = cyc;
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout at cycle %0d: got in_ready=%b, want 1", cyc, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.val = ref_max({8'h00, a}, {8'h00, b}, N2);
    e.at  = t0 + N2 + L + 1;
    q2.push_back(e);
    @(negedge clk);
    if (busy) begin
      in_a = 8'h11;
      in_b = 8'h22;
    end else begin
      in_valid = 1'b0;
    end
    ea = a;
    eb = b;
    for (int k = 0; k < N2; k++) begin
      check("nm_a", 32'(nm_a), 32'(ea[7:4]));
      check("nm_b", 32'(nm_b), 32'(eb[7:4]));
      check("in_ready_send", 32'(in_ready), 32'd0);
      ea = ea << 4;
      eb = eb << 4;
      @(negedge clk);
    end
    check("nm_a_after", 32'(nm_a), 32'd0);
    check("nm_b_after", 32'(nm_b), 32'd0);
    if (busy) begin
      while (cyc < t0 + N2 + L) begin
        check("in_ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain2();
    int guard;
    guard = 0;
    while (q2.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q2.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending, want 0", cyc, q2.size());
      q2.delete();
    end
  endtask

  initial begin : main
    int t0, t1, guard;
    reset = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mayor", 32'(out_mayor), 32'd0);
    check("rst_nm_a", 32'(nm_a), 32'd0);
    check("rst_nm_b", 32'(nm_b), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    send2(8'h3C, 8'h5A, 1'b0, t0);
    drain2();
    repeat (2) @(negedge clk);
    send2(8'h77, 8'h77, 1'b0, t0);
    send2(8'hF0, 8'h0F, 1'b0, t0);
    send2(8'h00, 8'h00, 1'b0, t0);
    drain2();
    @(negedge clk);
    send2(8'hC4, 8'h3B, 1'b1, t0);
    drain2();

    // Back-to-back: the second accept must land in the first result's DONE cycle.
    send2(8'h3C, 8'h5A, 1'b0, t0);
    send2(8'h9A, 8'hB1, 1'b0, t1);
    check("back_to_back_accept", 32'(t1), 32'(t0 + N2 + L + 1));
    drain2();

    // Reset mid-operation discards the pairs already in the comparator.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'hE7;
    in_b = 8'h3D;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_mayor", 32'(out_mayor), 32'd0);
    check("midrst_nm_a", 32'(nm_a), 32'd0);
    check("midrst_nm_b", 32'(nm_b), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    send2(8'h12, 8'h21, 1'b0, t0);
    drain2();

    for (int i = 0; i < 24; i++) begin
      send2(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), t0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain2();
    repeat (10) @(negedge clk);

    guard = 0;
    while (!done4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!done4) begin
      vectors++;
      miscompares++;
      $display("FAIL n4_timeout at cycle %0d: got done=0, want 1", cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : run4
    int guard;
    logic [15:0] a, b;
    exp_t e;
    reset4 = 1'b1;
    in_valid4 = 1'b0;
    in_a4 = '0;
    in_b4 = '0;
    repeat (2) @(negedge clk);
    reset4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 16'h1234 : 16'($urandom);
      b = (i == 0) ? 16'h4321 : 16'($urandom);
      in_valid4 = 1'b1;
      in_a4 = a;
      in_b4 = b;
      guard = 0;
      while (in_ready4 !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout4 at cycle %0d: got in_ready=%b, want 1", cyc, in_ready4);
      end else begin
        e.val = ref_max(a, b, N4);
        e.at  = cyc + N4 + L + 1;
        q4.push_back(e);
      end
      @(negedge clk);
      in_valid4 = 1'b0;
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    guard = 0;
    while (q4.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (q4.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout4 at cycle %0d: got %0d pending, want 0", cyc, q4.size());
    end
    done4 = 1'b1;
  end

endmodule

// File: doc/nibble_mayor_driver.md
Name: nibble_mayor_driver

Overview:
- Issuing and collecting end of the two-input nibble comparator interface.
- Accepts a pair of multi-nibble operands over a valid/ready handshake.
- Drives the comparator one nibble pair per cycle, MSB nibble first, and tracks in-flight pairs with a tag shift register matched to the comparator's fixed pipeline latency.
- Reassembles the returned per-nibble maxima into a result word with a one-cycle completion pulse.

Parameters:
- N_PARES, 2, number of nibble pairs per operand; operand width W = 4*N_PARES.
- LATENCIA, 4, cycles from a pair being presented on nm_a/nm_b until its maximum is valid on nm_mayor.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- nm_a  out  4  nibble of A to comparator.
- nm_b  out  4  nibble of B to comparator.
- nm_mayor  in  4  comparator result nibble.
- out_valid  out  1  one-cycle pulse: out_mayor complete.
- out_mayor  out  W  per-nibble maxima, nibble i = max(A[i], B[i]).

Behaviour:
- Reset (async, asserted any time):
  - state = IDLE; in_ready = 1; out_valid = 0; out_mayor = 0; nm_a = nm_b = 0.
  - Operand registers, issue counter, tag shift register and capture counter all cleared.
  - Results still in flight in the comparator are discarded, because no tags remain.
- All outputs are registered.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - If in_valid is high at the edge: latch in_a/in_b, clear the issue and capture counters, go to SEND.
- SEND (exactly N_PARES cycles):
  - Cycle k (k = 0..N_PARES-1) presents nm_a = A nibble N_PARES-1-k and nm_b = the matching B nibble.
  - Each presented pair pushes a 1 into tag_sr[0]; idle cycles push 0.
  - After the last pair: go to WAIT, and nm_a/nm_b return to 0.
- tag_sr:
  - LATENCIA stages; shifts every cycle in every state.
  - When tag_sr[LATENCIA-1] = 1 in a cycle, nm_mayor is valid that cycle.
  - At the end of that cycle, nm_mayor is written into out_mayor nibble N_PARES-1-capture_count, and capture_count increments.
  - Net effect: the result for the pair presented in cycle t is captured at the end of cycle t+LATENCIA.
- WAIT: when the N_PARES-th capture occurs, go to DONE.
- DONE (exactly one cycle):
  - out_valid = 1 and in_ready = 1.
  - An accept in this cycle goes directly to SEND; otherwise go to IDLE.
- out_mayor:
  - Capture order is MSB nibble first.
  - Stale nibbles from the previous result stay visible until overwritten.
  - out_mayor is only meaningful while out_valid = 1.
- Latency: accept edge at end of cycle T0; pairs presented in cycles T0+1..T0+N_PARES; out_valid in cycle T0+N_PARES+LATENCIA+1 (cycle T0+7 at default parameters).
- Throughput: one operand pair per N_PARES+LATENCIA+1 cycles.
- in_valid while in_ready = 0 is ignored; the source must hold its data until accepted.
- Equal nibbles return that value; no tie flag.
- nm_mayor is ignored whenever tag_sr[LATENCIA-1] = 0.

Test Plan:
- Basic: reset, then accept A=0x3C, B=0x5A at T0 -> nm_a/nm_b = 3/5 in T0+1 and C/A in T0+2; out_valid=1 with out_mayor=0x5C in T0+7 only.
- Equal and extreme values: A=0x77, B=0x77 -> 0x77; A=0xF0, B=0x0F -> 0xFF; A=0x00, B=0x00 -> 0x00.
- Busy: in_valid held high with new data 0x11/0x22 during SEND/WAIT -> in_ready=0 and no latch; the first result is unchanged.
- Back-to-back: second accept (0x9A/0xB1) in the DONE cycle of the first -> second out_valid exactly 7 cycles later, out_mayor=0xBA.
- Reset mid-operation: assert reset in cycle T0+3 -> out_valid/out_mayor/nm_a/nm_b = 0 immediately. After release, a new transaction 0x12/0x21 -> 0x22, with no stray capture from discarded pairs.
- Bench model: behavioural comparator with LATENCIA=4 connected; also run N_PARES=4, A=0x1234, B=0x4321 -> out_mayor=0x4334 in T0+9.
